note_detector: RTL and testbench



---
 rtl/note_detect_pkg.sv | 41 ++++
 rtl/tone_sync_edge.sv | 14 +
 rtl/note_detector.sv | 133 +++++++++++++
 tb/tb_note_detector.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/note_detect_pkg.sv
// note_detect_pkg: note indices, frequency table, period/threshold helpers and FSM states
package note_detect_pkg;

    localparam logic [3:0] NOTE_C4   = 4'd0;
    localparam logic [3:0] NOTE_CS4  = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_DS4  = 4'd3;
    localparam logic [3:0] NOTE_E4   = 4'd4;
    localparam logic [3:0] NOTE_F4   = 4'd5;
    localparam logic [3:0] NOTE_FS4  = 4'd6;
    localparam logic [3:0] NOTE_G4   = 4'd7;
    localparam logic [3:0] NOTE_GS4  = 4'd8;
    localparam logic [3:0] NOTE_A4   = 4'd9;
    localparam logic [3:0] NOTE_AS4  = 4'd10;
    localparam logic [3:0] NOTE_B4   = 4'd11;
    localparam logic [3:0] NOTE_NONE = 4'd15;

    localparam int unsigned NOTE_FREQ [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY} state_t;

    // full period in clk cycles, matching the tone generators' half-period rounding
    function automatic int unsigned note_period(input int unsigned clk_hz, input logic [3:0] k);
        return 2 * (clk_hz / 2 / NOTE_FREQ[k] + 1);
    endfunction

    // midpoint to the next higher note; entry 11 is the lower band limit
    function automatic int unsigned note_thresh(input int unsigned clk_hz, input logic [3:0] k);
        int unsigned p11 = note_period(clk_hz, 4'd11);
        if (k < 4'd11)
            return (note_period(clk_hz, k) + note_period(clk_hz, k + 4'd1)) / 2;
        return p11 - (note_period(clk_hz, 4'd10) - p11) / 2;
    endfunction

    // periods above this are slower than anything near C4
    function automatic int unsigned note_upper(input int unsigned clk_hz);
        int unsigned p0 = note_period(clk_hz, 4'd0);
        return p0 + (p0 - note_period(clk_hz, 4'd1)) / 2;
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: 2-FF synchroniser for an async pin plus rising-edge pulse
module tone_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic [2:0] sr;
    // two synchroniser stages followed by one history stage for edge detection
    always_ff @(posedge clk)
        if (reset) sr <= '0;
        else sr <= {sr[1:0], din};
    assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/note_detector.sv
// note_detector: measures the tone_in period and classifies it as C4..B4 (NOTE_CONFIRM_EN: commit only on two agreeing classifications)
module note_detector
    import note_detect_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int          CNT_W       = 25,
    parameter int unsigned TIMEOUT_CYC = 400_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tone_in,
    output logic [3:0]       note_idx,
    output logic             note_valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period
);
    localparam logic [CNT_W-1:0] UPPER   = CNT_W'(note_upper(CLK_HZ));
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);

    state_t           state, state_d;
    logic             rise, agree, valid_d, strobe_d;
    logic [CNT_W-1:0] cnt, cnt_d, per_q, per_q_d, period_d;
    logic [3:0]       k, k_d, hit, hit_d, hit_now, res, idx_d;
    logic [CNT_W-1:0] thr [12];
`ifdef NOTE_CONFIRM_EN
    logic [3:0]       cand, cand_d;
`endif

    tone_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (tone_in),
        .rise  (rise)
    );

    for (genvar i = 0; i < 12; i++) begin : g_thr
        assign thr[i] = CNT_W'(note_thresh(CLK_HZ, 4'(i)));
    end

    // next-state, counter, sequential table scan and output update
    always_comb begin
        state_d  = state;
        cnt_d    = &cnt ? cnt : cnt + 1'b1;
        per_q_d  = per_q;
        k_d      = k;
        hit_d    = hit;
        idx_d    = note_idx;
        valid_d  = note_valid;
        strobe_d = 1'b0;
        period_d = period;
        hit_now  = (hit == NOTE_NONE && per_q > thr[k]) ? k : hit;
        res      = per_q > UPPER ? NOTE_NONE : hit_now;
`ifdef NOTE_CONFIRM_EN
        cand_d   = cand;
        agree    = res == cand;
`else
        agree    = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    per_q_d = cnt + 1'b1;
                    cnt_d   = '0;
                    hit_d   = NOTE_NONE;
                    state_d = CLASSIFY;
                end else if (cnt == TIMEOUT) begin
                    state_d  = IDLE;
                    idx_d    = NOTE_NONE;
                    valid_d  = 1'b0;
                    strobe_d = note_valid;
`ifdef NOTE_CONFIRM_EN
                    cand_d   = NOTE_NONE;
`endif
                end
            end
            CLASSIFY: begin
                if (rise) cnt_d = '0;
                hit_d = hit_now;
                k_d   = k == 4'd11 ? 4'd0 : k + 4'd1;
                if (k == 4'd11) begin
                    state_d = MEASURE;
`ifdef NOTE_CONFIRM_EN
                    cand_d  = res;
`endif
                    if (agree) begin
                        idx_d    = res;
                        valid_d  = res != NOTE_NONE;
                        period_d = per_q;
                        strobe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            per_q       <= '0;
            k           <= '0;
            hit         <= NOTE_NONE;
            note_idx    <= NOTE_NONE;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
            period      <= '0;
`ifdef NOTE_CONFIRM_EN
            cand        <= NOTE_NONE;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            per_q       <= per_q_d;
            k           <= k_d;
            hit         <= hit_d;
            note_idx    <= idx_d;
            note_valid  <= valid_d;
            note_strobe <= strobe_d;
            period      <= period_d;
`ifdef NOTE_CONFIRM_EN
            cand        <= cand_d;
`endif
        end
    end
endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed checks of note_detector at CLK_HZ=1 MHz (periods: C4 3818, F4 2866, A4 2274; band 1966..3921)
module tb_note_detector;
    import note_detect_pkg::*;

    localparam int TMO = 5000;
`ifdef NOTE_CONFIRM_EN
    localparam bit CONF = 1'b1;
`else
    localparam bit CONF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tone_in = 1'b0;
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_strobe;
    logic [15:0] period;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, strobes = 0, first_strobe_cyc = -1;
    int s0, t0;
    int rises[$];

    note_detector #(.CLK_HZ(1_000_000), .CNT_W(16), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .tone_in     (tone_in),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .note_strobe (note_strobe),
        .period      (period)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (note_strobe) begin
            if (strobes == 0) first_strobe_cyc = cyc;
            strobes++;
        end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // n full periods of p cycles, each starting with a rising edge; called on a negedge
    task automatic tone(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            tone_in = 1'b1;
            rises.push_back(cyc);
            repeat (p / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic check_out(input string tag, input int idx, input int valid, input int per, input int nstr);
        check({tag, "_idx"}, note_idx, idx);
        check({tag, "_valid"}, note_valid, valid);
        check({tag, "_period"}, period, per);
        check({tag, "_strobes"}, strobes - s0, nstr);
    endtask

    initial begin
        check("pkg_p_f4_50m", note_period(50_000_000, NOTE_F4), 143268);
        check("pkg_p_a4_50m", note_period(50_000_000, NOTE_A4), 113638);
        check("pkg_lower_50m", note_thresh(50_000_000, NOTE_B4), 98175);
        check("pkg_upper_50m", note_upper(50_000_000), 196007);

        // reset held while tone_in toggles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tone_in = ~tone_in;
        end
        s0 = 0;
        check_out("reset", 15, 0, 0, 0);
        tone_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // F4 lock from IDLE: edge 1 only starts the count; strobe 3 sync + 12 scan cycles after the edge
        s0 = strobes;
        tone(2866, 4);
        check("f4_first_strobe_lat", first_strobe_cyc - rises[CONF ? 2 : 1], 15);
        check_out("f4", NOTE_F4, 1, 2866, CONF ? 2 : 3);

        // first edge of each block closes the previous block's last period
        s0 = strobes;
        tone(2274, 3);
        check_out("a4", NOTE_A4, 1, 2274, CONF ? 2 : 3);

        s0 = strobes;
        tone(1000, 3);
        check_out("short", 15, 0, 1000, CONF ? 2 : 3);

        s0 = strobes;
        tone(4000, 3);
        check_out("long", 15, 0, 4000, 3);

        // timeout: valid falls 3 sync + TMO counted + 1 register cycles after the last rising edge
        s0 = strobes;
        tone(2866, 3);
        check_out("f4_relock", NOTE_F4, 1, 2866, CONF ? 2 : 3);
        s0 = strobes;
        for (int i = 0; i < TMO + 100 && note_valid; i++) @(negedge clk);
        t0 = cyc - rises[rises.size() - 1];
        repeat (20) @(negedge clk);
        check("timeout_lat", t0, TMO + 4);
        check_out("timeout", 15, 0, 2866, 1);

        // from IDLE again: F4, one C4 period, then F4
        s0 = strobes;
        tone(2866, 3);
        check_out("f4_idle", NOTE_F4, 1, 2866, CONF ? 1 : 2);
        tone(3818, 1);
        s0 = strobes;
        tone(2866, 1);
        check_out("c4_between", CONF ? NOTE_F4 : NOTE_C4, 1, CONF ? 2866 : 3818, CONF ? 0 : 1);
        s0 = strobes;
        tone(2866, 2);
        check_out("f4_after_c4", NOTE_F4, 1, 2866, CONF ? 1 : 2);

        // single-cycle reset while locked
        s0 = strobes;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_out("mid_reset", 15, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
